// File: rtl/ssm_stream_sequencer_if.sv
// Word-stream handshakes around the SSM sequencer: operand words in, y words out.
interface ssm_stream_sequencer_if #(
    parameter int DW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/ssm_stream_sequencer.sv
// Streams operand words into the flat vectors of the SSM core, fires it once,
// then streams the captured y vector back out with a last flag.
module ssm_stream_sequencer #(
    parameter int B  = 1,
    parameter int H  = 4,
    parameter int P  = 4,
    parameter int N  = 4,
    parameter int DW = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    ssm_stream_sequencer_if.slave   strm,
    output logic [B*H*DW-1:0]       dt_flat,
    output logic [B*H*DW-1:0]       dA_flat,
    output logic [B*N*DW-1:0]       Bmat_flat,
    output logic [B*N*DW-1:0]       C_flat,
    output logic [H*DW-1:0]         D_flat,
    output logic [B*H*P*DW-1:0]     x_flat,
    output logic [B*H*P*N*DW-1:0]   h_prev_flat,
    output logic                    core_start,
    input  logic                    core_done,
    input  logic [B*H*P*DW-1:0]     y_flat,
    output logic                    busy
);
    localparam int N_DT   = B * H;
    localparam int N_BM   = B * N;
    localparam int N_X    = B * H * P;
    localparam int N_HP   = B * H * P * N;
    localparam int OFF_DA = N_DT;
    localparam int OFF_BM = OFF_DA + N_DT;
    localparam int OFF_C  = OFF_BM + N_BM;
    localparam int OFF_D  = OFF_C + N_BM;
    localparam int OFF_X  = OFF_D + H;
    localparam int OFF_HP = OFF_X + N_X;
    localparam int WIN    = OFF_HP + N_HP;
    localparam int WOUT   = N_X;
    localparam int CMAX   = (WIN > WOUT) ? WIN : WOUT;
    localparam int CW     = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FIRE  = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [DW-1:0]       slot_reg [WIN];
    logic [WOUT*DW-1:0]  ybuf_reg, ybuf_next;
    logic [DW-1:0]       out_data_reg, out_data_next;
    logic                core_start_reg;
    logic                busy_reg;
    logic                load_accept;
    logic                capture;
    logic                in_ready_c;
    logic                out_valid_c;
    logic                out_last_c;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        load_accept = 1'b0;
        capture     = 1'b0;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        out_last_c  = 1'b0;
        case (state_reg)
            LOAD: begin
                in_ready_c = 1'b1;
                if (strm.in_valid) begin
                    load_accept = 1'b1;
                    if (cnt_reg == CW'(WIN - 1)) begin
                        cnt_next   = '0;
                        state_next = FIRE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            // A done arriving in the start cycle itself is captured too.
            FIRE, WAIT: begin
                state_next = WAIT;
                if (core_done) begin
                    capture    = 1'b1;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                out_valid_c = 1'b1;
                out_last_c  = (cnt_reg == CW'(WOUT - 1));
                if (strm.out_ready) begin
                    if (out_last_c) begin
                        cnt_next   = '0;
                        state_next = LOAD;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = LOAD;
        endcase
    end

    // out_data is registered, so it is looked up with next-cycle state and count.
    always_comb begin
        ybuf_next     = capture ? y_flat : ybuf_reg;
        out_data_next = '0;
        if (state_next == DRAIN) begin
            out_data_next = ybuf_next[DW*int'(cnt_next) +: DW];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= LOAD;
            cnt_reg        <= '0;
            ybuf_reg       <= '0;
            out_data_reg   <= '0;
            core_start_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            ybuf_reg       <= ybuf_next;
            out_data_reg   <= out_data_next;
            core_start_reg <= (state_next == FIRE);
            busy_reg       <= (state_next != LOAD);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WIN; i++) begin
                slot_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIN; i++) begin
                if (load_accept && (cnt_reg == CW'(i))) begin
                    slot_reg[i] <= strm.in_data;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_DT; gi++) begin : g_dt
            assign dt_flat[DW*gi +: DW] = slot_reg[gi];
            assign dA_flat[DW*gi +: DW] = slot_reg[OFF_DA + gi];
        end
        for (gi = 0; gi < N_BM; gi++) begin : g_bm
            assign Bmat_flat[DW*gi +: DW] = slot_reg[OFF_BM + gi];
            assign C_flat[DW*gi +: DW]    = slot_reg[OFF_C + gi];
        end
        for (gi = 0; gi < H; gi++) begin : g_d
            assign D_flat[DW*gi +: DW] = slot_reg[OFF_D + gi];
        end
        for (gi = 0; gi < N_X; gi++) begin : g_x
            assign x_flat[DW*gi +: DW] = slot_reg[OFF_X + gi];
        end
        for (gi = 0; gi < N_HP; gi++) begin : g_hp
            assign h_prev_flat[DW*gi +: DW] = slot_reg[OFF_HP + gi];
        end
    endgenerate

    assign strm.in_ready  = in_ready_c;
    assign strm.out_valid = out_valid_c;
    assign strm.out_last  = out_last_c;
    assign strm.out_data  = out_data_reg;
    assign core_start     = core_start_reg;
    assign busy           = busy_reg;

endmodule
